// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops, shift-add multiply and restoring divide,
// with every result registered behind a valid/ready handshake.
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r2,
    output logic             z
);
    localparam logic [5:0] OP_AND   = 6'h00;
    localparam logic [5:0] OP_OR    = 6'h01;
    localparam logic [5:0] OP_ADD   = 6'h02;
    localparam logic [5:0] OP_ADDU  = 6'h03;
    localparam logic [5:0] OP_XOR   = 6'h04;
    localparam logic [5:0] OP_SUB   = 6'h06;
    localparam logic [5:0] OP_SLT   = 6'h07;
    localparam logic [5:0] OP_SLTU  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h09;
    localparam logic [5:0] OP_MULTU = 6'h13;
    localparam logic [5:0] OP_CLIP  = 6'h14;
    localparam logic [5:0] OP_MULT  = 6'h15;
    localparam logic [5:0] OP_DIV   = 6'h16;
    localparam logic [5:0] OP_DIVU  = 6'h17;
    localparam logic [5:0] OP_SLLV  = 6'h18;
    localparam logic [5:0] OP_SRLV  = 6'h19;
    localparam logic [5:0] OP_SRAV  = 6'h1A;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state_q, state_d;

    logic             init_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opb_q;
    logic             neg_q, neg_r_q;

    logic               accept, is_mul, is_div, is_signed, div_zero, last;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, fast_r, fast_r2;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] mul_next, mul_res;
    logic [WIDTH-1:0]   div_hi_next, div_lo_next, quo_res, rem_res;

    assign is_mul    = (ctrl == OP_MULTU) || (ctrl == OP_MULT);
    assign is_div    = (ctrl == OP_DIV) || (ctrl == OP_DIVU);
    assign is_signed = (ctrl == OP_MULT) || (ctrl == OP_DIV);
    assign div_zero  = is_div && (b == '0);
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign sh        = a[SHW-1:0];
    assign accept    = in_valid && in_ready;
    assign last      = &cnt_q;

    always_comb begin
        fast_r  = '0;
        fast_r2 = '0;
        case (ctrl)
            OP_AND:          fast_r = a & b;
            OP_OR:           fast_r = a | b;
            OP_ADD, OP_ADDU: fast_r = a + b;
            OP_XOR:          fast_r = a ^ b;
            OP_SUB:          fast_r = a - b;
            OP_SLT:          fast_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:         fast_r = {{(WIDTH-1){1'b0}}, a < b};
            OP_LUI:          fast_r = b << (WIDTH/2);
            OP_CLIP: begin
                if ($signed(a) > $signed(b)) fast_r = b;
                else if (a[WIDTH-1])         fast_r = '0;
                else                         fast_r = a;
            end
            OP_SLLV:         fast_r = b << sh;
            OP_SRLV:         fast_r = b >> sh;
            OP_SRAV:         fast_r = $unsigned($signed(b) >>> sh);
            // only reaches the result registers when the divisor is zero
            OP_DIV, OP_DIVU: begin
                fast_r  = '1;
                fast_r2 = a;
            end
            default: ;
        endcase
    end

    // hi:lo is the partial product / multiplier pair, or remainder / dividend pair
    assign mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next    = {mul_sum, lo_q[WIDTH-1:1]};
    assign mul_res     = neg_q ? -mul_next : mul_next;
    assign rem_sh      = {hi_q, lo_q[WIDTH-1]};
    assign rem_diff    = rem_sh - {1'b0, opb_q};
    assign div_hi_next = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    assign div_lo_next = {lo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
    assign quo_res     = neg_q ? -div_lo_next : div_lo_next;
    assign rem_res     = neg_r_q ? -div_hi_next : div_hi_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = init_q;
                if (in_valid && init_q) begin
                    if (is_mul)                    state_d = MUL;
                    else if (is_div && !div_zero)  state_d = DIV;
                    else                           state_d = DONE;
                end
            end
            MUL:  if (last) state_d = DONE;
            DIV:  if (last) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            r       <= '0;
            r2      <= '0;
            z       <= 1'b1;
        end else begin
            init_q <= 1'b1;
            case (state_q)
                IDLE: if (accept) begin
                    cnt_q   <= '0;
                    hi_q    <= '0;
                    lo_q    <= a_mag;
                    opb_q   <= b_mag;
                    neg_q   <= a_neg ^ b_neg;
                    neg_r_q <= a_neg;
                    if (!is_mul && (!is_div || div_zero)) begin
                        r  <= fast_r;
                        r2 <= fast_r2;
                        z  <= (fast_r == '0);
                    end
                end
                MUL: begin
                    cnt_q        <= cnt_q + SHW'(1);
                    {hi_q, lo_q} <= mul_next;
                    if (last) begin
                        r  <= mul_res[WIDTH-1:0];
                        r2 <= mul_res[2*WIDTH-1:WIDTH];
                        z  <= (mul_res[WIDTH-1:0] == '0);
                    end
                end
                DIV: begin
                    cnt_q <= cnt_q + SHW'(1);
                    hi_q  <= div_hi_next;
                    lo_q  <= div_lo_next;
                    if (last) begin
                        r  <= quo_res;
                        r2 <= rem_res;
                        z  <= (quo_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32 and WIDTH=16 against an arithmetic
// reference model; a monitor checks results, latency, hold-stability and handshake.
module tb_seq_alu;
    localparam int ND = 2;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] r2;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [ND-1:0]       in_valid_v, out_ready_v, bp;
    logic [ND-1:0][5:0]  ctrl_v;
    logic [ND-1:0][31:0] a_v, b_v;
    logic [ND-1:0]       in_ready_v, out_valid_v, z_v;
    logic [ND-1:0][31:0] r_v, r2_v;

    logic        in_ready0, out_valid0, z0, in_ready1, out_valid1, z1;
    logic [31:0] r0, r2_0;
    logic [15:0] r1, r2_1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q [ND][$];

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready0),
        .ctrl(ctrl_v[0]), .a(a_v[0]), .b(b_v[0]), .out_valid(out_valid0),
        .out_ready(out_ready_v[0]), .r(r0), .r2(r2_0), .z(z0)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready1),
        .ctrl(ctrl_v[1]), .a(a_v[1][15:0]), .b(b_v[1][15:0]), .out_valid(out_valid1),
        .out_ready(out_ready_v[1]), .r(r1), .r2(r2_1), .z(z1)
    );

    assign in_ready_v  = {in_ready1, in_ready0};
    assign out_valid_v = {out_valid1, out_valid0};
    assign z_v         = {z1, z0};
    assign r_v         = {{16'h0, r1}, r0};
    assign r2_v        = {{16'h0, r2_1}, r2_0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, act, exp, cyc);
        end
    endtask

    function automatic longint sx(input longint unsigned v, input int w);
        if (((v >> (w - 1)) & 1) != 0) return longint'(v) - (longint'(1) <<< w);
        return longint'(v);
    endfunction

    // Reference: w-bit semantics computed with 64-bit integer arithmetic.
    function automatic void model(input int w, input logic [5:0] c, input logic [31:0] av,
                                  input logic [31:0] bv, output exp_t e);
        longint unsigned m, ua, ub, res, res2;
        longint sa, sb;
        int sh;
        m    = (64'd1 << w) - 1;
        ua   = 64'(av) & m;
        ub   = 64'(bv) & m;
        sa   = sx(ua, w);
        sb   = sx(ub, w);
        sh   = int'(ua % 64'(w));
        res  = 0;
        res2 = 0;
        e    = '0;
        e.lat = 1;
        case (c)
            6'h00: res = ua & ub;
            6'h01: res = ua | ub;
            6'h02, 6'h03: res = ua + ub;
            6'h04: res = ua ^ ub;
            6'h06: res = ua - ub;
            6'h07: res = (sa < sb) ? 1 : 0;
            6'h08: res = (ua < ub) ? 1 : 0;
            6'h09: res = ub << (w / 2);
            6'h14: res = (sa > sb) ? ub : ((sa < 0) ? 0 : ua);
            6'h18: res = ub << sh;
            6'h19: res = ub >> sh;
            6'h1A: res = longint'(sb >>> sh);
            6'h13: begin res = ua * ub; res2 = res >> w; e.lat = w + 1; end
            6'h15: begin res = sa * sb; res2 = res >> w; e.lat = w + 1; end
            6'h16: begin
                if (ub == 0) begin res = m; res2 = ua; end
                else begin res = sa / sb; res2 = sa % sb; e.lat = w + 1; end
            end
            6'h17: begin
                if (ub == 0) begin res = m; res2 = ua; end
                else begin res = ua / ub; res2 = ua % ub; e.lat = w + 1; end
            end
            default: ;
        endcase
        e.r  = 32'(res & m);
        e.r2 = 32'(res2 & m);
        e.z  = (e.r == 0);
    endfunction

    task automatic issue(input int d, input logic [5:0] c, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        int n;
        @(negedge clk);
        in_valid_v[d] = 1'b1;
        ctrl_v[d]     = c;
        a_v[d]        = av;
        b_v[d]        = bv;
        n = 0;
        while (!in_ready_v[d] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_v[d]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: in_ready still 0 after %0d cycles", d, n);
            in_valid_v[d] = 1'b0;
            return;
        end
        model(d == 0 ? 32 : 16, c, av, bv, e);
        e.acc = cyc + 1;
        exp_q[d].push_back(e);
        @(posedge clk);
        #1;
        // scramble the inputs to prove the operands were captured on accept
        in_valid_v[d] = 1'b0;
        ctrl_v[d]     = 6'($urandom);
        a_v[d]        = $urandom;
        b_v[d]        = $urandom;
    endtask

    function automatic logic [31:0] pick(input int w);
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'(1) << (w - 1);
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        out_ready_v = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < ND; d++)
                out_ready_v[d] = bp[d] ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    logic [ND-1:0] prev_v = '0, prev_take = '0;
    exp_t cur [ND];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v    = '0;
            prev_take = '0;
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (prev_take[d]) begin
                    chk("handoff_valid", d, out_valid_v[d], 0);
                    chk("handoff_ready", d, in_ready_v[d], 1);
                end
                if (out_valid_v[d]) begin
                    chk("busy_ready", d, in_ready_v[d], 0);
                    if (!prev_v[d]) begin
                        if (exp_q[d].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_result dut%0d: got r=%0h with nothing outstanding", d, r_v[d]);
                            cur[d] = '{r: r_v[d], r2: r2_v[d], z: z_v[d], lat: 0, acc: 0};
                        end else begin
                            cur[d] = exp_q[d].pop_front();
                            chk("r", d, r_v[d], cur[d].r);
                            chk("r2", d, r2_v[d], cur[d].r2);
                            chk("z", d, z_v[d], cur[d].z);
                            chk("latency", d, cyc - cur[d].acc + 1, cur[d].lat);
                        end
                    end else begin
                        chk("hold_r", d, r_v[d], cur[d].r);
                        chk("hold_r2", d, r2_v[d], cur[d].r2);
                        chk("hold_z", d, z_v[d], cur[d].z);
                    end
                end
                prev_v[d]    = out_valid_v[d];
                prev_take[d] = out_valid_v[d] && out_ready_v[d];
            end
        end
    end

    task automatic check_reset_outputs(input string nm);
        for (int d = 0; d < ND; d++) begin
            chk({nm, "_valid"}, d, out_valid_v[d], 0);
            chk({nm, "_r"}, d, r_v[d], 0);
            chk({nm, "_r2"}, d, r2_v[d], 0);
            chk({nm, "_z"}, d, z_v[d], 1);
            chk({nm, "_ready"}, d, in_ready_v[d], 0);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) chk("ready_before_edge", d, in_ready_v[d], 0);
        @(negedge clk);
        for (int d = 0; d < ND; d++) chk("ready_after_edge", d, in_ready_v[d], 1);
    endtask

    logic [5:0] ops [17] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                             6'h14, 6'h18, 6'h19, 6'h1A, 6'h13, 6'h15, 6'h16, 6'h17};

    initial begin
        rst_n = 1'b0;
        bp = '0;
        in_valid_v = '0;
        ctrl_v = '0;
        a_v = '0;
        b_v = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_reset();

        issue(0, 6'h02, 32'h7FFF_FFFF, 32'h1);
        issue(0, 6'h06, 32'd5, 32'd5);
        issue(0, 6'h15, 32'hFFFF_FFFF, 32'd3);
        issue(0, 6'h13, 32'hFFFF_FFFF, 32'd3);
        issue(0, 6'h16, -32'sd7, 32'd2);
        issue(0, 6'h17, 32'd7, 32'd0);
        issue(0, 6'h16, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(0, 6'h1A, 32'd31, 32'h8000_0000);
        issue(0, 6'h18, 32'h25, 32'h1);
        issue(0, 6'h14, -32'sd4, 32'd10);
        issue(0, 6'h14, 32'd50, 32'd10);
        issue(0, 6'h07, -32'sd1, 32'd1);
        issue(0, 6'h08, -32'sd1, 32'd1);
        issue(0, 6'h09, 32'h0, 32'h1234_ABCD);
        issue(0, 6'h05, 32'h1, 32'h2);
        issue(1, 6'h13, 32'hFFFF, 32'hFFFF);
        issue(1, 6'h16, 32'h8000, 32'hFFFF);
        issue(1, 6'h16, 32'hFFF9, 32'h0);

        // back-pressure: hold the DIV result, with the next op already offered
        bp[0] = 1'b1;
        fork
            begin
                issue(0, 6'h16, -32'sd100, 32'd7);
                issue(0, 6'h02, 32'd1, 32'd2);
            end
            begin
                for (int n = 0; n < 500 && !out_valid_v[0]; n++) @(negedge clk);
                chk("bp_result_reached", 0, out_valid_v[0], 1);
                repeat (10) @(negedge clk);
                bp[0] = 1'b0;
            end
        join

        // reset in the middle of a multiply must abort it with no late result
        issue(0, 6'h15, 32'h1234_5678, -32'sd99);
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        release_reset();
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (out_valid_v[0]) seen++;
            end
            chk("late_valid", 0, seen, 0);
        end
        issue(0, 6'h3F, 32'hDEAD_BEEF, 32'h1);

        for (int i = 0; i < 250; i++) begin
            int d;
            logic [5:0] c;
            d = $urandom_range(0, 1);
            c = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 16)];
            issue(d, c, pick(d == 0 ? 32 : 16), pick(d == 0 ? 32 : 16));
        end

        for (int n = 0; n < 1000 && (exp_q[0].size() != 0 || exp_q[1].size() != 0 || out_valid_v != '0); n++)
            @(negedge clk);
        chk("drain_pending", 0, exp_q[0].size() + exp_q[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
